// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, ALU codes,
// datapath mux selects, opcode/funct constants and the memory access-size helper.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_TRAP   = 4'd10
    } state_e;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'b0000,
        ALU_ADD  = 4'b0001,
        ALU_SUB  = 4'b0010,
        ALU_AND  = 4'b0011,
        ALU_OR   = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_NOR  = 4'b1001,
        ALU_LUI  = 4'b1010,
        ALU_XOR  = 4'b1011,
        ALU_SRA  = 4'b1100
    } alu_op_e;

    localparam logic [1:0] NPC_ALU = 2'b00, NPC_BRANCH = 2'b01, NPC_JUMP = 2'b10, NPC_REG = 2'b11;
    localparam logic [1:0] WD_ALU = 2'b00, WD_MDR = 2'b01, WD_PC = 2'b10;
    localparam logic [1:0] GPR_RD = 2'b00, GPR_RT = 2'b01, GPR_RA = 2'b10;
    localparam logic [1:0] SRCA_PC = 2'b00, SRCA_RS = 2'b01, SRCA_SHAMT = 2'b10;
    localparam logic [1:0] SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SL2 = 2'b11;
    localparam logic [1:0] MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111, OP_LB   = 6'b100000, OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011, OP_LBU  = 6'b100100, OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000, OP_SH   = 6'b101001, OP_SW   = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000, FN_SRL  = 6'b000010, FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000, FN_JALR = 6'b001001, FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001, FN_SUB  = 6'b100010, FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100, FN_OR   = 6'b100101, FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111, FN_SLT  = 6'b101010, FN_SLTU = 6'b101011;

    function automatic logic [1:0] mem_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: mem_size = MEM_BYTE;
            OP_LH, OP_LHU, OP_SH: mem_size = MEM_HALF;
            default:              mem_size = MEM_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: maps op/funct to the ALU code, immediate extension
// mode, and the R-type / immediate-shift qualifiers used by the EXEC state.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic       is_rtype,
    output logic       is_shift_imm
);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        alu_op       = ALU_NOP;
        ext_op       = 1'b0;
        is_rtype     = (op == OP_RTYPE);
        is_shift_imm = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SLL:          begin alu_op = ALU_SLL; is_shift_imm = 1'b1; end
                FN_SRL:          begin alu_op = ALU_SRL; is_shift_imm = 1'b1; end
                FN_SRA:          begin alu_op = ALU_SRA; is_shift_imm = 1'b1; end
                FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                FN_AND:          alu_op = ALU_AND;
                FN_OR:           alu_op = ALU_OR;
                FN_XOR:          alu_op = ALU_XOR;
                FN_NOR:          alu_op = ALU_NOR;
                FN_SLT:          alu_op = ALU_SLT;
                FN_SLTU:         alu_op = ALU_SLTU;
                default:         alu_op = ALU_NOP;
            endcase
        end else begin
            case (op)
                OP_ADDI: begin alu_op = ALU_ADD; ext_op = 1'b1; end
                OP_SLTI: begin alu_op = ALU_SLT; ext_op = 1'b1; end
                OP_ANDI: alu_op = ALU_AND;
                OP_ORI:  alu_op = ALU_OR;
                OP_LUI:  alu_op = ALU_LUI;
                default: alu_op = ALU_NOP;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath through fetch, decode,
// execute, memory and write-back, stalling on mem_ack and trapping on bad opcodes or timeouts.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_op,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] npc_op,
    output logic       reg_we,
    output logic [1:0] gpr_sel,
    output logic [1:0] wd_sel,
    output logic [1:0] alu_srca,
    output logic [1:0] alu_srcb,
    output logic [3:0] alu_op,
    output logic       ext_op,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;

    logic [3:0] dec_alu_op;
    logic       dec_ext_op, is_rtype, is_shift_imm;

    mc_alu_dec u_alu_dec (
        .op           (op),
        .funct        (funct),
        .alu_op       (dec_alu_op),
        .ext_op       (dec_ext_op),
        .is_rtype     (is_rtype),
        .is_shift_imm (is_shift_imm)
    );

    logic is_load, is_store, is_branch, is_jreg, is_jump, is_link, is_alu;

    assign is_load   = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
    assign is_store  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign is_jreg   = is_rtype && ((funct == FN_JR) || (funct == FN_JALR));
    assign is_jump   = (op == OP_J) || (op == OP_JAL) || is_jreg;
    assign is_link   = (op == OP_JAL) || (is_rtype && (funct == FN_JALR));
    assign is_alu    = (is_rtype && !is_jreg) || (op == OP_ADDI) || (op == OP_ORI) ||
                       (op == OP_ANDI) || (op == OP_SLTI) || (op == OP_LUI);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    assign state   = state_q;
    assign illegal = (state_q == ST_TRAP);

    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_op   = MEM_BYTE;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        npc_op   = NPC_ALU;
        reg_we   = 1'b0;
        gpr_sel  = GPR_RD;
        wd_sel   = WD_ALU;
        alu_srca = SRCA_PC;
        alu_srcb = SRCB_RT;
        alu_op   = ALU_NOP;
        ext_op   = 1'b0;
        retire   = 1'b0;

        // Outputs are gated by rst itself so strobes drop before the next edge.
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_op   = MEM_WORD;
                    alu_srcb = SRCB_FOUR;
                    alu_op   = ALU_ADD;
                    if (mem_ack) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_srcb = SRCB_IMM_SL2;
                    alu_op   = ALU_ADD;
                    ext_op   = 1'b1;
                    if (is_load || is_store) state_d = ST_MEMADR;
                    else if (is_branch)      state_d = ST_BRANCH;
                    else if (is_jump)        state_d = ST_JUMP;
                    else if (is_alu)         state_d = ST_EXEC;
                    else                     state_d = ST_TRAP;
                end
                ST_MEMADR: begin
                    alu_srca = SRCA_RS;
                    alu_srcb = SRCB_IMM;
                    alu_op   = ALU_ADD;
                    ext_op   = 1'b1;
                    state_d  = is_store ? ST_MEMWR : ST_MEMRD;
                end
                ST_MEMRD: begin
                    mem_req = 1'b1;
                    mem_op  = mem_size(op);
                    if (mem_ack) state_d = ST_MEMWB;
                end
                ST_MEMWB: begin
                    // Access size stays visible so the datapath can extend the loaded data.
                    mem_op  = mem_size(op);
                    reg_we  = 1'b1;
                    wd_sel  = WD_MDR;
                    gpr_sel = GPR_RT;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    mem_op  = mem_size(op);
                    if (mem_ack) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_EXEC: begin
                    alu_op   = dec_alu_op;
                    alu_srca = is_shift_imm ? SRCA_SHAMT : SRCA_RS;
                    alu_srcb = is_rtype ? SRCB_RT : SRCB_IMM;
                    ext_op   = dec_ext_op;
                    state_d  = ST_ALUWB;
                end
                ST_ALUWB: begin
                    reg_we  = 1'b1;
                    wd_sel  = WD_ALU;
                    gpr_sel = is_rtype ? GPR_RD : GPR_RT;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_srca = SRCA_RS;
                    alu_srcb = SRCB_RT;
                    alu_op   = ALU_SUB;
                    pc_we    = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
                    npc_op   = NPC_BRANCH;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_we   = 1'b1;
                    npc_op  = is_jreg ? NPC_REG : NPC_JUMP;
                    reg_we  = is_link;
                    wd_sel  = is_link ? WD_PC : WD_ALU;
                    gpr_sel = is_link ? GPR_RA : GPR_RD;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_TRAP:  state_d = ST_TRAP;
                default:  state_d = ST_TRAP;
            endcase

            // A late ack in the final allowed cycle still completes the access.
            if (mem_req && !mem_ack) begin
                if (tmo_q == TMO_LAST) state_d = ST_TRAP;
                else                   tmo_d   = tmo_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl (MEM_TIMEOUT=4): walks representative instructions cycle by
// cycle and compares every strobe against hand-derived values.
module tb_mc_ctrl;

    logic       clk, rst, zero, mem_ack;
    logic [5:0] op, funct;
    logic       mem_req, mem_we, ir_we, pc_we, reg_we, ext_op, retire, illegal;
    logic [1:0] mem_op, npc_op, gpr_sel, wd_sel, alu_srca, alu_srcb;
    logic [3:0] alu_op, state;

    int checks = 0;
    int errors = 0;
    int retire_cnt = 0;
    int rc;

    mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_op(mem_op), .ir_we(ir_we), .pc_we(pc_we),
        .npc_op(npc_op), .reg_we(reg_we), .gpr_sel(gpr_sel), .wd_sel(wd_sel),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .ext_op(ext_op),
        .retire(retire), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (retire === 1'b1) retire_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // FETCH with immediate ack then DECODE; leaves the bench in the third cycle, before sampling.
    task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input string tag);
        op = o; funct = f; mem_ack = 1'b1;
        smp(); check({tag, "_f_state"}, state, 0); check({tag, "_f_irwe"}, ir_we, 1);
        adv(); mem_ack = 1'b0;
        smp(); check({tag, "_d_state"}, state, 1);
        adv();
    endtask

    initial begin
        rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0;
        #12;
        check("rst_state", state, 0); check("rst_memreq", mem_req, 0);
        check("rst_illegal", illegal, 0); check("rst_irwe", ir_we, 0);
        adv(); rst = 1'b0;

        // addu: 4 cycles, one retire
        rc = retire_cnt;
        op = 6'b000000; funct = 6'b100001; mem_ack = 1'b1;
        smp(); check("add_f_state", state, 0); check("add_f_req", mem_req, 1);
        check("add_f_irwe", ir_we, 1); check("add_f_pcwe", pc_we, 1);
        check("add_f_memop", mem_op, 2); check("add_f_srcb", alu_srcb, 1); check("add_f_alu", alu_op, 1);
        adv(); smp(); check("add_d_state", state, 1); check("add_d_srcb", alu_srcb, 3); check("add_d_ext", ext_op, 1);
        adv(); smp(); check("add_e_state", state, 6); check("add_e_alu", alu_op, 1);
        check("add_e_srca", alu_srca, 1); check("add_e_srcb", alu_srcb, 0); check("add_e_regwe", reg_we, 0);
        adv(); smp(); check("add_w_state", state, 7); check("add_w_regwe", reg_we, 1);
        check("add_w_gpr", gpr_sel, 0); check("add_w_retire", retire, 1);
        adv();
        check("add_retires", retire_cnt - rc, 1);

        // lw: ack after 3 stall cycles in FETCH (ack at the timeout boundary) and 2 in MEMRD
        rc = retire_cnt;
        op = 6'b100011; funct = 6'b000000; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp(); check("lw_fstall_state", state, 0); check("lw_fstall_irwe", ir_we, 0); check("lw_fstall_req", mem_req, 1);
            adv();
        end
        mem_ack = 1'b1;
        smp(); check("lw_f4_state", state, 0); check("lw_f4_irwe", ir_we, 1);
        adv(); mem_ack = 1'b0;
        smp(); check("lw_d_state", state, 1);
        adv(); smp(); check("lw_a_state", state, 2); check("lw_a_srca", alu_srca, 1);
        check("lw_a_srcb", alu_srcb, 2); check("lw_a_ext", ext_op, 1);
        adv();
        for (int i = 0; i < 2; i++) begin
            smp(); check("lw_rstall_state", state, 3); check("lw_rstall_we", mem_we, 0); check("lw_rstall_memop", mem_op, 2);
            adv();
        end
        mem_ack = 1'b1;
        smp(); check("lw_r3_state", state, 3);
        adv(); mem_ack = 1'b0;
        smp(); check("lw_wb_state", state, 4); check("lw_wb_wd", wd_sel, 1); check("lw_wb_gpr", gpr_sel, 1);
        check("lw_wb_memop", mem_op, 2); check("lw_wb_regwe", reg_we, 1); check("lw_wb_retire", retire, 1);
        adv(); smp(); check("lw_next_state", state, 0);
        check("lw_retires", retire_cnt - rc, 1);
        adv();

        // beq taken / not taken (the lw's follow-on FETCH already consumed one stall cycle)
        zero = 1'b1;
        fetch_decode(6'b000100, 6'b000000, "beq1");
        smp(); check("beq1_state", state, 8); check("beq1_pcwe", pc_we, 1); check("beq1_npc", npc_op, 1);
        check("beq1_alu", alu_op, 2); check("beq1_retire", retire, 1);
        adv(); zero = 1'b0;
        fetch_decode(6'b000100, 6'b000000, "beq0");
        smp(); check("beq0_pcwe", pc_we, 0); check("beq0_retire", retire, 1); check("beq0_npc", npc_op, 1);
        adv();

        // jal / jr
        fetch_decode(6'b000011, 6'b000000, "jal");
        smp(); check("jal_state", state, 9); check("jal_pcwe", pc_we, 1); check("jal_npc", npc_op, 2);
        check("jal_regwe", reg_we, 1); check("jal_wd", wd_sel, 2); check("jal_gpr", gpr_sel, 2);
        adv();
        fetch_decode(6'b000000, 6'b001000, "jr");
        smp(); check("jr_npc", npc_op, 3); check("jr_regwe", reg_we, 0); check("jr_pcwe", pc_we, 1);
        adv();

        // illegal opcode traps after DECODE
        fetch_decode(6'b111111, 6'b000000, "ill");
        smp(); check("ill_state", state, 10); check("ill_flag", illegal, 1); check("ill_req", mem_req, 0);
        adv(); adv(); smp(); check("ill_hold", illegal, 1);
        adv(); rst = 1'b1;
        smp(); check("ill_rst_flag", illegal, 0); check("ill_rst_state", state, 0);
        adv(); rst = 1'b0;

        // FETCH timeout: four unacked request cycles then TRAP
        op = 6'b000000; funct = 6'b100001; mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp(); check("tmo_req", mem_req, 1); check("tmo_state", state, 0);
            adv();
        end
        mem_ack = 1'b1;
        smp(); check("tmo_trap_state", state, 10); check("tmo_illegal", illegal, 1); check("tmo_trap_req", mem_req, 0);
        adv(); adv(); smp(); check("tmo_hold_state", state, 10); check("tmo_hold_illegal", illegal, 1);
        adv(); rst = 1'b1; adv(); rst = 1'b0;

        // sh: reset asserted mid-MEMWR drops the request within the same cycle
        fetch_decode(6'b101001, 6'b000000, "sh");
        smp(); check("sh_a_state", state, 2);
        adv();
        smp(); check("sh_w_state", state, 5); check("sh_w_req", mem_req, 1);
        check("sh_w_we", mem_we, 1); check("sh_w_memop", mem_op, 1);
        #1 rst = 1'b1;
        #1 check("sh_rst_req", mem_req, 0); check("sh_rst_we", mem_we, 0); check("sh_rst_state", state, 0);
        rc = retire_cnt;
        adv(); rst = 1'b0; mem_ack = 1'b0;
        smp(); check("sh_post_state", state, 0); check("sh_post_retire", retire, 0); check("sh_post_req", mem_req, 1);
        adv();
        check("sh_post_retires", retire_cnt - rc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
